// File: rtl/instr_fetch_unit_if.sv
// Instruction memory fetch bus: the sequencer drives request/address,
// memory returns the instruction word with an acknowledge.
interface instr_fetch_unit_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ack
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction sequencer: owns the PC, fetches words over a req/ack bus,
// presents opcode/operand to the decoder and selects the next PC from
// the decoder's jump/inc once the datapath signals exec_done.
// Optional feature macro: FETCH_TIMEOUT_EN (fetch watchdog raising fault).
module instr_fetch_unit #(
  parameter int              PC_W        = 8,
  parameter int              INSTR_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC    = {PC_W{1'b0}},
  parameter int              TIMEOUT_CYC = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  instr_fetch_unit_if.master    imem,
  output logic [3:0]            opcode,
  output logic [INSTR_W-5:0]    operand,
  output logic                  instr_valid,
  input  logic                  jump,
  input  logic                  inc,
  input  logic                  exec_done,
  output logic                  halted,
  output logic                  fault
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_HALT  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  state_t             state_r;
  logic [PC_W-1:0]    pc_r;
  logic [INSTR_W-1:0] ir_r;
  logic               req_r;
  logic               valid_r;
  logic               halted_r;
  logic [PC_W-1:0]    pc_inc_s;
  logic [PC_W-1:0]    jump_target_s;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] wait_cnt_r;
  logic             fault_r;
`endif

  // Next-PC candidates: sequential increment (wraps) and jump target
  // taken from the operand field, truncated or zero-extended to PC_W.
  always_comb begin
    pc_inc_s      = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
    jump_target_s = PC_W'(ir_r[INSTR_W-5:0]);
  end

  // Sequencer FSM with registered request/valid/status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      pc_r       <= RESET_PC;
      ir_r       <= {INSTR_W{1'b0}};
      req_r      <= 1'b0;
      valid_r    <= 1'b0;
      halted_r   <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt_r <= {CNT_W{1'b0}};
      fault_r    <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r    <= ST_FETCH;
          req_r      <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
          wait_cnt_r <= {CNT_W{1'b0}};
`endif
        end
        ST_FETCH: begin
          if (imem.imem_ack) begin
            // Ack wins even on the edge the watchdog would expire.
            ir_r    <= imem.imem_rdata;
            state_r <= ST_ISSUE;
            req_r   <= 1'b0;
            valid_r <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
          end else if (wait_cnt_r == CNT_LAST) begin
            state_r  <= ST_FAULT;
            req_r    <= 1'b0;
            halted_r <= 1'b1;
            fault_r  <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
`else
          end else begin
            state_r <= ST_FETCH;
          end
`endif
        end
        ST_ISSUE: begin
          if (exec_done) begin
            if (jump || inc) begin
              pc_r       <= jump ? jump_target_s : pc_inc_s;
              state_r    <= ST_FETCH;
              req_r      <= 1'b1;
              valid_r    <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
              wait_cnt_r <= {CNT_W{1'b0}};
`endif
            end else begin
              state_r  <= ST_HALT;
              valid_r  <= 1'b0;
              halted_r <= 1'b1;
            end
          end else begin
            state_r <= ST_ISSUE;
          end
        end
        ST_HALT: begin
          state_r <= ST_HALT;
        end
        ST_FAULT: begin
          state_r <= ST_FAULT;
        end
        default: begin
          state_r  <= ST_IDLE;
          req_r    <= 1'b0;
          valid_r  <= 1'b0;
          halted_r <= 1'b0;
        end
      endcase
    end
  end

  assign imem.imem_req  = req_r;
  assign imem.imem_addr = pc_r;
  assign opcode         = ir_r[INSTR_W-1:INSTR_W-4];
  assign operand        = ir_r[INSTR_W-5:0];
  assign instr_valid    = valid_r;
  assign halted         = halted_r;
`ifdef FETCH_TIMEOUT_EN
  assign fault          = fault_r;
`else
  assign fault          = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: instruction-level reference
// model (memory array + PC arithmetic) with a per-cycle compare process,
// directed pins for the key scenarios, then randomized programs.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        jump = 1'b0;
  logic        inc = 1'b0;
  logic        exec_done = 1'b0;
  logic [3:0]  opcode;
  logic [11:0] operand;
  logic        instr_valid;
  logic        halted;
  logic        fault;

  instr_fetch_unit_if #(.PC_W(8), .INSTR_W(16)) bus ();

  instr_fetch_unit #(.PC_W(8), .INSTR_W(16), .RESET_PC(8'h00), .TIMEOUT_CYC(15)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (bus),
    .opcode      (opcode),
    .operand     (operand),
    .instr_valid (instr_valid),
    .jump        (jump),
    .inc         (inc),
    .exec_done   (exec_done),
    .halted      (halted),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [15:0] mem [256];
  int          mpc;
  logic        chk_en = 1'b0;
  logic        exp_req, exp_valid, exp_halted, exp_fault, exp_zero;
  logic [7:0]  exp_addr;
  logic [15:0] exp_word;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // per-cycle comparison against the model's expected outputs
  always @(negedge clk) begin
    if (chk_en) begin
      chk("imem_req", bus.imem_req, exp_req);
      chk("instr_valid", instr_valid, exp_valid);
      chk("halted", halted, exp_halted);
      chk("fault", fault, exp_fault);
      if (exp_req || exp_zero) chk("imem_addr", bus.imem_addr, exp_addr);
      if (exp_valid) begin
        chk("opcode", opcode, exp_word >> 12);
        chk("operand", operand, exp_word & 16'h0FFF);
      end
      if (exp_zero) begin
        chk("opcode_rst", opcode, 0);
        chk("operand_rst", operand, 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input logic req, input logic valid, input logic hlt,
                         input logic flt, input logic zero);
    exp_req = req; exp_valid = valid; exp_halted = hlt;
    exp_fault = flt; exp_zero = zero;
    exp_addr = 8'(mpc);
  endtask

  task automatic quiet_inputs();
    bus.imem_ack = 1'b0; bus.imem_rdata = 16'h0000;
    exec_done = 1'b0; jump = 1'b0; inc = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.imem_ack = 1'b1;            // must be overridden by reset
    step();
    mpc = 0;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    quiet_inputs();
    step();
    rst_n = 1'b1;                   // next cycle is the single IDLE cycle
    step();
    set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // DUT is in FETCH at pc=mpc; stall dly cycles then acknowledge
  task automatic fetch_instr(input int dly);
    for (int k = 0; k < dly; k++) begin
      bus.imem_ack = 1'b0; bus.imem_rdata = 16'($urandom);
      exec_done = 1'($urandom); jump = 1'($urandom); inc = 1'($urandom);
      step();
    end
    bus.imem_ack = 1'b1; bus.imem_rdata = mem[mpc];
    exec_done = 1'b0;
    step();
    exp_word = mem[mpc];
    set_exp(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // DUT is in ISSUE; wait dly cycles then exec_done with given jump/inc
  task automatic issue_instr(input int dly, input logic j, input logic i);
    for (int k = 0; k < dly; k++) begin
      exec_done = 1'b0; jump = 1'($urandom); inc = 1'($urandom);
      bus.imem_ack = 1'($urandom); bus.imem_rdata = 16'($urandom);
      step();
    end
    exec_done = 1'b1; jump = j; inc = i;
    bus.imem_ack = 1'($urandom); bus.imem_rdata = 16'($urandom);
    step();
    quiet_inputs();
    if (j) begin
      mpc = (exp_word & 16'h0FFF) % 256;
      set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end else if (i) begin
      mpc = (mpc + 1) % 256;
      set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end else begin
      set_exp(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
  endtask

  // hold in a terminal state while inputs toggle randomly
  task automatic hold_random(input int n);
    for (int k = 0; k < n; k++) begin
      bus.imem_ack = 1'($urandom); bus.imem_rdata = 16'($urandom);
      exec_done = 1'($urandom); jump = 1'($urandom); inc = 1'($urandom);
      step();
    end
    quiet_inputs();
  endtask

  initial begin
    int ctl;
    quiet_inputs();
    set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
    mem[8'h00] = 16'h1234;
    mem[8'h01] = 16'h8A05;
    mem[8'h05] = 16'h70FF;
    mem[8'hFF] = 16'h0000;

    // reset then first fetch at 0x00
    do_reset();
    chk("first_req", bus.imem_req, 1'b1);
    chk("first_addr", bus.imem_addr, 8'h00);

    // 0x1234 with inc
    fetch_instr(1);
    chk("lit_opcode", opcode, 4'h1);
    chk("lit_operand", operand, 12'h234);
    chk("lit_valid", instr_valid, 1'b1);
    issue_instr(1, 1'b0, 1'b1);
    chk("lit_inc_addr", bus.imem_addr, 8'h01);

    // 0x8A05: jump priority, target truncated
    fetch_instr(0);
    issue_instr(0, 1'b1, 1'b1);
    chk("lit_jump_addr", bus.imem_addr, 8'h05);

    // jump to 0xFF then inc wraps to 0x00
    fetch_instr(2);
    issue_instr(0, 1'b1, 1'b0);
    chk("lit_ff_addr", bus.imem_addr, 8'hFF);
    fetch_instr(0);
    issue_instr(2, 1'b0, 1'b1);
    chk("lit_wrap_addr", bus.imem_addr, 8'h00);

    // halt: no jump, no inc
    fetch_instr(0);
    issue_instr(0, 1'b0, 1'b0);
    chk("lit_halted", halted, 1'b1);
    hold_random(20);
    chk("lit_halt_req", bus.imem_req, 1'b0);
    do_reset();
    chk("lit_restart_addr", bus.imem_addr, 8'h00);

`ifdef FETCH_TIMEOUT_EN
    // no ack: fault after 15 wait cycles
    for (int k = 0; k < 14; k++) step();
    step();
    set_exp(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("lit_fault", fault, 1'b1);
    hold_random(6);
    do_reset();
    // ack on the 15th cycle wins
    fetch_instr(14);
    chk("lit_ack15_valid", instr_valid, 1'b1);
    chk("lit_ack15_fault", fault, 1'b0);
`else
    // without the watchdog a long stall just waits
    fetch_instr(20);
    chk("lit_stall_valid", instr_valid, 1'b1);
    chk("lit_stall_fault", fault, 1'b0);
`endif
    issue_instr(0, 1'b0, 1'b1);

    // reset mid-fetch drops the request at that edge, even with ack high
    step();
    rst_n = 1'b0;
    bus.imem_ack = 1'b1;
    step();
    mpc = 0;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("lit_midfetch_req", bus.imem_req, 1'b0);
    quiet_inputs();
    rst_n = 1'b1;
    step();
    set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // randomized programs
    for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
    for (int n = 0; n < 300; n++) begin
      fetch_instr($urandom_range(0, 3));
      ctl = $urandom_range(0, 19);
      if (ctl == 0) begin
        issue_instr($urandom_range(0, 3), 1'b0, 1'b0);
        hold_random(4);
        do_reset();
      end else if (ctl < 8) begin
        issue_instr($urandom_range(0, 3), 1'b1, 1'($urandom));
      end else begin
        issue_instr($urandom_range(0, 3), 1'b0, 1'b1);
      end
    end

    step();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
